fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage directly upstream of the instruction memory: holds the program counter, drives `address` into INST_MEM, and captures the returned word into an IF/ID pipeline register for the decode stage. Supports sequential fetch, stall, and redirect by branch, jump and jump-register. Redirects squash the wrong-path fetch. INST_MEM reads combinationally: `inst_in` is valid in the same cycle as `address`.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `stall`  in  1  hold PC and IF/ID contents (hazard from downstream)
- `branch_taken`  in  1  redirect to `branch_target`
- `branch_target`  in  32  branch destination byte address
- `jump`  in  1  redirect to pseudo-direct jump target
- `jump_index`  in  26  J-type instruction index field
- `jr`  in  1  redirect to `jr_target`
- `jr_target`  in  32  register-sourced destination
- `inst_in`  in  32  instruction word from INST_MEM `inst_out`
- `address`  out  32  current PC, drives INST_MEM `address`
- `if_id_inst`  out  32  latched instruction for decode
- `if_id_pc4`  out  32  PC+4 of the latched instruction
- `if_id_valid`  out  1  latched instruction is real (not bubble)
- `misalign_err`  out  1  one-cycle pulse: redirect target had bits [1:0] != 0
- `fetch_count`  out  32  count of instructions delivered (valid captures)

## Operation
- Registers: `pc`, `if_id_inst`, `if_id_pc4`, `if_id_valid`, `misalign_err`, `fetch_count`. `address` = `pc` continuously.
- Next-PC priority per edge (highest first): reset, `jr`, `jump`, `branch_taken`, `stall`, sequential.
- Reset: `pc`=RESET_PC, `if_id_inst`=0, `if_id_pc4`=0, `if_id_valid`=0, `misalign_err`=0, `fetch_count`=0.
- Jump target = {`if_id_pc4`[31:28], `jump_index`, 2'b00} (jump is resolved in decode).
- Redirect (any of jr/jump/branch): `pc` <= target with bits [1:0] forced to 0; IF/ID flushed (`if_id_inst`=0, `if_id_valid`=0, `if_id_pc4` unchanged); `fetch_count` unchanged. Redirect overrides `stall`.
- `misalign_err` <= 1 for exactly one cycle when the selected redirect target has nonzero [1:0]; otherwise 0. Only the winning source is checked.
- Stall (no redirect): `pc`, IF/ID registers and `fetch_count` hold.
- Sequential: `pc` <= `pc`+4 (mod 2^32); `if_id_inst` <= `inst_in`, `if_id_pc4` <= `pc`+4, `if_id_valid` <= 1, `fetch_count` <= `fetch_count`+1 (mod 2^32).
- All adds are 32-bit unsigned, carry discarded.

## Timing
- Reset held: `address`=RESET_PC from the edge after reset sampled high; IF/ID invalid.
- First edge with reset low: IF/ID captures word at RESET_PC with valid=1; `address` becomes RESET_PC+4.
- Fetch latency: word at `address` in cycle N appears on `if_id_inst` in cycle N+1.
- Redirect sampled in cycle N: `address`=target in N+1, `if_id_valid`=0 in N+1, target's word in IF/ID in N+2.
- Stall in cycle N: outputs in N+1 equal outputs in N.
- Reset mid-stream or concurrent with redirect/stall: reset wins, all state to reset values on that edge.
- Wrap: `pc`=32'hFFFF_FFFC sequential -> `pc`=0, `if_id_pc4`=0.

## Test plan
- Reset then 6 free cycles, INST_MEM preloaded: `address` steps 0,4,8,12,16,20; `if_id_pc4` trails 4,8,...; `fetch_count`=6; `if_id_valid`=1 from cycle 1.
- Stall at PC=8 for 3 cycles: `address` stays 8, `if_id_inst`/`if_id_pc4`=4's word/8 held, `fetch_count` frozen; resumes 12 after release.
- `branch_taken`=1, `branch_target`=0x40 at PC=12: next `address`=0x40, `if_id_valid`=0; following cycle `if_id_inst`=word at 0x40.
- `jump`=1, `jump_index`=26'h10 with `if_id_pc4`=0x0000_0010: `address`=0x40; simultaneous `jr`=1, `jr_target`=0x100 -> `address`=0x100 (jr wins); with `stall`=1 also -> still 0x100.
- `jr_target`=0x102: `address`=0x100, `misalign_err` high exactly one cycle.
- RESET_PC=32'hFFFF_FFFC, one sequential edge: `address`=0, `if_id_pc4`=0; assert reset mid-run -> `address`=FFFF_FFFC, `fetch_count`=0, `if_id_valid`=0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch stage and its neighbours (redirect sources,
// INST_MEM and the decode stage). The master modport is the fetch unit's view.
interface fetch_unit_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] inst_in;
    logic [31:0] address;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        misalign_err;
    logic [31:0] fetch_count;

    modport master (
        input  stall, branch_taken, branch_target, jump, jump_index,
               jr, jr_target, inst_in,
        output address, if_id_inst, if_id_pc4, if_id_valid,
               misalign_err, fetch_count
    );

    modport slave (
        output stall, branch_taken, branch_target, jump, jump_index,
               jr, jr_target, inst_in,
        input  address, if_id_inst, if_id_pc4, if_id_valid,
               misalign_err, fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses INST_MEM combinationally and
// latches the returned word into the IF/ID register; handles stall and redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    logic [31:0] pc;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        misalign_err;
    logic [31:0] fetch_count;

    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] redirect_target;
    logic        redirect;

    assign pc_plus4    = pc + 32'd4;
    // Jump is resolved in decode, so its region bits come from the instruction in IF/ID.
    assign jump_target = {if_id_pc4[31:28], bus.jump_index, 2'b00};

    // Only the highest-priority redirect source is selected (and misalignment-checked).
    always_comb begin
        redirect        = 1'b0;
        redirect_target = 32'h0;
        if (bus.jr) begin
            redirect        = 1'b1;
            redirect_target = bus.jr_target;
        end else if (bus.jump) begin
            redirect        = 1'b1;
            redirect_target = jump_target;
        end else if (bus.branch_taken) begin
            redirect        = 1'b1;
            redirect_target = bus.branch_target;
        end
    end

    // if_id_valid marks a real instruction for decode; a cleared bit is a bubble
    // that decode must ignore. There is no back-pressure other than stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_PC;
            if_id_inst   <= 32'h0;
            if_id_pc4    <= 32'h0;
            if_id_valid  <= 1'b0;
            misalign_err <= 1'b0;
            fetch_count  <= 32'h0;
        end else if (redirect) begin
            pc           <= {redirect_target[31:2], 2'b00};
            if_id_inst   <= 32'h0;
            if_id_valid  <= 1'b0;
            misalign_err <= |redirect_target[1:0];
        end else begin
            misalign_err <= 1'b0;
            if (!bus.stall) begin
                pc          <= pc_plus4;
                if_id_inst  <= bus.inst_in;
                if_id_pc4   <= pc_plus4;
                if_id_valid <= 1'b1;
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

    assign bus.address      = pc;
    assign bus.if_id_inst   = if_id_inst;
    assign bus.if_id_pc4    = if_id_pc4;
    assign bus.if_id_valid  = if_id_valid;
    assign bus.misalign_err = misalign_err;
    assign bus.fetch_count  = fetch_count;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (RESET_PC 0 and FFFF_FFFC) share one stimulus
// stream and are checked every cycle against a rule-level model and a fetch queue.
module tb_fetch_unit;
    localparam logic [31:0] HI_RESET_PC = 32'hFFFF_FFFC;

    logic clk;
    logic reset;

    fetch_unit_if if0 ();
    fetch_unit_if if1 ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .reset(reset), .bus(if0.master)
    );
    fetch_unit #(.RESET_PC(HI_RESET_PC)) u_dut_hi (
        .clk(clk), .reset(reset), .bus(if1.master)
    );

    // ---------------- clock / reset block ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // INST_MEM contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    assign if0.inst_in = mem_word(if0.address);
    assign if1.inst_in = mem_word(if1.address);

    assign if1.stall         = if0.stall;
    assign if1.branch_taken  = if0.branch_taken;
    assign if1.branch_target = if0.branch_target;
    assign if1.jump          = if0.jump;
    assign if1.jump_index    = if0.jump_index;
    assign if1.jr            = if0.jr;
    assign if1.jr_target     = if0.jr_target;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        valid;
        logic        mis;
        logic [31:0] cnt;
    } st_t;

    st_t m0, m1;

    function automatic st_t model_next(input st_t s, input logic [31:0] rpc);
        st_t n;
        logic [31:0] tgt;
        logic        redir;
        n     = s;
        redir = if0.jr | if0.jump | if0.branch_taken;
        if (if0.jr)             tgt = if0.jr_target;
        else if (if0.jump)      tgt = {s.pc4[31:28], if0.jump_index, 2'b00};
        else                    tgt = if0.branch_target;
        if (reset) begin
            n = '{pc: rpc, inst: 32'h0, pc4: 32'h0, valid: 1'b0, mis: 1'b0, cnt: 32'h0};
        end else if (redir) begin
            n.pc    = tgt & 32'hFFFF_FFFC;
            n.inst  = 32'h0;
            n.valid = 1'b0;
            n.mis   = (tgt % 4) != 0;
        end else if (if0.stall) begin
            n.mis = 1'b0;
        end else begin
            n.pc    = s.pc + 32'd4;
            n.inst  = mem_word(s.pc);
            n.pc4   = s.pc + 32'd4;
            n.valid = 1'b1;
            n.mis   = 1'b0;
            n.cnt   = s.cnt + 32'd1;
        end
        return n;
    endfunction

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        check("addr0",  if0.address,             m0.pc);
        check("inst0",  if0.if_id_inst,          m0.inst);
        check("pc4_0",  if0.if_id_pc4,           m0.pc4);
        check("valid0", 32'(if0.if_id_valid),    32'(m0.valid));
        check("mis0",   32'(if0.misalign_err),   32'(m0.mis));
        check("cnt0",   if0.fetch_count,         m0.cnt);
        check("addr1",  if1.address,             m1.pc);
        check("inst1",  if1.if_id_inst,          m1.inst);
        check("pc4_1",  if1.if_id_pc4,           m1.pc4);
        check("valid1", 32'(if1.if_id_valid),    32'(m1.valid));
        check("mis1",   32'(if1.misalign_err),   32'(m1.mis));
        check("cnt1",   if1.fetch_count,         m1.cnt);
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic rst, input logic st, input logic br,
                          input logic [31:0] bt, input logic j, input logic [25:0] ji,
                          input logic r, input logic [31:0] rt);
        reset             = rst;
        if0.stall         = st;
        if0.branch_taken  = br;
        if0.branch_target = bt;
        if0.jump          = j;
        if0.jump_index    = ji;
        if0.jr            = r;
        if0.jr_target     = rt;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    endtask

    // One clock: predict, advance, compare; captured words flow through exp_q.
    task automatic step();
        st_t n0, n1;
        logic [31:0] prev_cnt;
        logic        was_reset;
        n0 = model_next(m0, 32'h0);
        n1 = model_next(m1, HI_RESET_PC);
        was_reset = reset;
        prev_cnt  = if0.fetch_count;
        if (reset) exp_q.delete();
        else if (!(if0.jr | if0.jump | if0.branch_taken | if0.stall))
            exp_q.push_back(mem_word(m0.pc));
        @(posedge clk);
        #1;
        m0 = n0;
        m1 = n1;
        compare_all();
        if (!was_reset && if0.fetch_count !== prev_cnt) begin
            if (exp_q.size() == 0) check("sb_underflow", 32'd0, 32'd1);
            else check("sb_inst", if0.if_id_inst, exp_q.pop_front());
        end
    endtask

    task automatic reset_then_free(input int n);
        set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        step();
        idle();
        repeat (n) step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle();
        reset = 1'b1;
        @(negedge clk);
        step();
        step();
        check("rst_addr",  if0.address, 32'h0);
        check("rst_valid", 32'(if0.if_id_valid), 32'd0);
        check("rst_addr_hi", if1.address, HI_RESET_PC);

        // Six free-running fetches; the high instance wraps on the first one.
        idle();
        for (int i = 0; i < 6; i++) begin
            step();
            check("seq_addr", if0.address, 32'(4 * (i + 1)));
            check("seq_pc4",  if0.if_id_pc4, 32'(4 * (i + 1)));
            check("seq_valid", 32'(if0.if_id_valid), 32'd1);
            if (i == 0) begin
                check("wrap_addr_hi", if1.address, 32'h0);
                check("wrap_pc4_hi",  if1.if_id_pc4, 32'h0);
            end
        end
        check("seq_cnt", if0.fetch_count, 32'd6);

        // Reset mid-run.
        reset = 1'b1;
        step();
        check("midrst_addr_hi", if1.address, HI_RESET_PC);
        check("midrst_cnt_hi",  if1.fetch_count, 32'h0);
        check("midrst_valid_hi", 32'(if1.if_id_valid), 32'd0);

        // Stall at PC=8 for three cycles, then resume and branch at PC=12.
        idle();
        step();
        step();
        if0.stall = 1'b1;
        repeat (3) begin
            step();
            check("stall_addr", if0.address, 32'd8);
            check("stall_inst", if0.if_id_inst, mem_word(32'd4));
            check("stall_pc4",  if0.if_id_pc4, 32'd8);
            check("stall_cnt",  if0.fetch_count, 32'd2);
        end
        idle();
        step();
        check("resume_addr", if0.address, 32'd12);
        set_in(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 26'h0, 1'b0, 32'h0);
        step();
        check("br_addr",  if0.address, 32'h40);
        check("br_valid", 32'(if0.if_id_valid), 32'd0);
        idle();
        step();
        check("br_inst", if0.if_id_inst, mem_word(32'h40));

        // Jump resolved with if_id_pc4 = 0x10.
        reset_then_free(4);
        check("pre_jump_pc4", if0.if_id_pc4, 32'h10);
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h10, 1'b0, 32'h0);
        step();
        check("jump_addr", if0.address, 32'h40);

        reset_then_free(4);
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h10, 1'b1, 32'h100);
        step();
        check("jr_win_addr", if0.address, 32'h100);

        reset_then_free(4);
        set_in(1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 26'h10, 1'b1, 32'h100);
        step();
        check("jr_stall_addr", if0.address, 32'h100);

        set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h102);
        step();
        check("mis_addr",  if0.address, 32'h100);
        check("mis_pulse", 32'(if0.misalign_err), 32'd1);
        idle();
        step();
        check("mis_clear", 32'(if0.misalign_err), 32'd0);

        // Wrap on the default instance via a jr to the last word.
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFC);
        step();
        idle();
        step();
        check("wrap_addr", if0.address, 32'h0);
        check("wrap_pc4",  if0.if_id_pc4, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] bt, rt;
            bt = $urandom();
            rt = $urandom();
            if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
            set_in($urandom_range(0, 49) == 0,
                   $urandom_range(0, 4) == 0,
                   $urandom_range(0, 9) == 0, bt,
                   $urandom_range(0, 19) == 0, 26'($urandom()),
                   $urandom_range(0, 19) == 0, rt);
            step();
        end
        idle();
        step();
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
